tone_synth: RTL

Downstream audio stage for the UART piano: consumes the 24-bit `tone` word and the `volume` bit and produces the speaker drive. It generates a 50%-duty square wave whose half-period is `tone` clock cycles, with glitch-free retuning and a PWM amplitude level. `tone == 0` means silence.

---
 rtl/tone_synth_pkg.sv | 12 +
 rtl/tone_synth_pwm_level.sv | 26 ++
 rtl/tone_synth.sv | 115 +++++++++++
 3 files changed

// File: rtl/tone_synth_pkg.sv
// Shared types and default widths for the tone synthesiser.
package tone_synth_pkg;

    typedef enum logic {
        SILENT = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam int TONE_W_DEF  = 24;
    localparam int LEVEL_W_DEF = 4;

endpackage

// File: rtl/tone_synth_pwm_level.sv
// Free-running PWM counter compared against the requested amplitude level.
module pwm_level
    import tone_synth_pkg::*;
#(
    parameter int LEVEL_W = LEVEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] level,
    output logic               pwm_on
);

    logic [LEVEL_W-1:0] r_pwm_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // All-ones level must be solid on, which the strict compare alone cannot give.
    assign pwm_on = (&level) | (r_pwm_cnt < level);

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone generator: half-period retunes only at phase boundaries, PWM-scaled speaker drive.
module tone_synth
    import tone_synth_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int TONE_W     = TONE_W_DEF,
    parameter int LEVEL_W    = LEVEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TONE_W-1:0]  tone,
    input  logic               volume,
    input  logic [LEVEL_W-1:0] level,
    output logic               square_out,
    output logic               speaker,
    output logic               tone_active,
    output logic               period_done
);

    if (CLOCK_FREQ <= 0) begin : g_bad_clock_freq
        $error("tone_synth: CLOCK_FREQ must be positive");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [TONE_W-1:0]  r_cur_tone;
    logic [TONE_W-1:0]  w_cur_tone_next;
    logic [TONE_W-1:0]  r_half_cnt;
    logic [TONE_W-1:0]  w_half_cnt_next;
    logic               r_square;
    logic               w_square_next;
    logic               r_period_done;
    logic               w_period_done_next;
    logic               r_speaker;
    logic [TONE_W-1:0]  w_tone_last;
    logic               w_boundary;
    logic               w_pwm_on;

    pwm_level #(
        .LEVEL_W (LEVEL_W)
    ) u_pwm_level (
        .clk    (clk),
        .rst    (rst),
        .level  (level),
        .pwm_on (w_pwm_on)
    );

    // cur_tone is never 0 in RUN, so the decrement cannot wrap there.
    assign w_tone_last = r_cur_tone - 1'b1;
    assign w_boundary  = (r_half_cnt == w_tone_last);

    always_comb begin
        w_state_next       = r_state;
        w_cur_tone_next    = r_cur_tone;
        w_half_cnt_next    = r_half_cnt;
        w_square_next      = r_square;
        w_period_done_next = 1'b0;

        case (r_state)
            SILENT: begin
                w_half_cnt_next = '0;
                w_square_next   = 1'b0;
                if (tone != '0) begin
                    w_cur_tone_next = tone;
                    w_square_next   = 1'b1;
                    w_state_next    = RUN;
                end
            end
            RUN: begin
                if (!w_boundary) begin
                    w_half_cnt_next = r_half_cnt + 1'b1;
                end else begin
                    // tone is only looked at here, so a running half-period never shortens.
                    w_half_cnt_next = '0;
                    if (tone == '0) begin
                        w_square_next = 1'b0;
                        w_state_next  = SILENT;
                    end else begin
                        w_cur_tone_next    = tone;
                        w_square_next      = ~r_square;
                        w_period_done_next = ~r_square;
                    end
                end
            end
            default: begin
                w_state_next  = SILENT;
                w_square_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= SILENT;
            r_cur_tone    <= '0;
            r_half_cnt    <= '0;
            r_square      <= 1'b0;
            r_period_done <= 1'b0;
            r_speaker     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cur_tone    <= w_cur_tone_next;
            r_half_cnt    <= w_half_cnt_next;
            r_square      <= w_square_next;
            r_period_done <= w_period_done_next;
            r_speaker     <= r_square & volume & w_pwm_on;
        end
    end

    assign square_out  = r_square;
    assign speaker     = r_speaker;
    assign tone_active = (r_state == RUN);
    assign period_done = r_period_done;

endmodule
